// File: rtl/preg_reclaim_unit.sv
// preg_reclaim_unit: stages released physical registers and returns them to the free list one per cycle
module preg_reclaim_unit #(
    parameter int PREG_WIDTH      = 5,
    parameter int STAGE_DEPTH     = 8,
    parameter int STAGE_PTR_WIDTH = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       c0_valid,
    input  logic                       c0_has_dest,
    input  logic [PREG_WIDTH-1:0]      c0_preg,
    input  logic                       c1_valid,
    input  logic                       c1_has_dest,
    input  logic [PREG_WIDTH-1:0]      c1_preg,
    input  logic                       sq_valid,
    input  logic [PREG_WIDTH-1:0]      sq_preg,
    output logic                       in_ready,
    input  logic                       fl_full,
    output logic                       fl_wr_en,
    output logic [PREG_WIDTH-1:0]      fl_wdata,
    input  logic                       drain_req,
    output logic                       drain_done,
    output logic [STAGE_PTR_WIDTH:0]   stage_count
);
    localparam int CW = STAGE_PTR_WIDTH + 1;
    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] DRAIN = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]                 state, state_next;
    logic [STAGE_PTR_WIDTH-1:0] rd_ptr, wr_ptr, p1, p2;
    logic [CW-1:0]              count, count_next;
    logic [PREG_WIDTH-1:0]      queue [STAGE_DEPTH];
    logic                       v0, v1, vs;
    logic [1:0]                 nenq;

    assign v0          = c0_valid & c0_has_dest & (c0_preg != '0);
    assign v1          = c1_valid & c1_has_dest & (c1_preg != '0);
    assign vs          = sq_valid & (sq_preg != '0);
    assign in_ready    = (state == RUN) && (count <= CW'(STAGE_DEPTH - 3));
    assign nenq        = in_ready ? {1'b0, v0} + {1'b0, v1} + {1'b0, vs} : 2'd0;
    assign p1          = wr_ptr + STAGE_PTR_WIDTH'(v0);
    assign p2          = p1 + STAGE_PTR_WIDTH'(v1);
    assign fl_wr_en    = (count != '0) && !fl_full;
    assign fl_wdata    = queue[rd_ptr];
    assign count_next  = count + CW'(nenq) - CW'(fl_wr_en);
    assign drain_done  = (state == DONE);
    assign stage_count = count;

    // drain sequencing: RUN -> DRAIN until the queue empties -> one-cycle DONE
    always_comb begin
        state_next = (state == RUN)   ? (drain_req ? DRAIN : RUN) :
                     (state == DRAIN) ? ((count_next == '0) ? DONE : DRAIN) : RUN;
    end

    // pointers, occupancy and state
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            state  <= RUN;
        end else begin
            wr_ptr <= wr_ptr + STAGE_PTR_WIDTH'(nenq);
            rd_ptr <= rd_ptr + STAGE_PTR_WIDTH'(fl_wr_en);
            count  <= count_next;
            state  <= state_next;
        end
    end

    // qualified lanes packed contiguously at wr_ptr in c0, c1, sq order
    always_ff @(posedge clk) begin
        if (in_ready) begin
            if (v0) queue[wr_ptr] <= c0_preg;
            if (v1) queue[p1] <= c1_preg;
            if (vs) queue[p2] <= sq_preg;
        end
    end
endmodule

// File: tb/tb_preg_reclaim_unit.sv
// tb_preg_reclaim_unit: directed vector table plus scoreboarded wrap and reset-in-drain sequences
module tb_preg_reclaim_unit;
    logic       clk = 0, reset = 1;
    logic       c0_valid = 0, c0_has_dest = 0, c1_valid = 0, c1_has_dest = 0, sq_valid = 0;
    logic [4:0] c0_preg = 0, c1_preg = 0, sq_preg = 0;
    logic       fl_full = 0, drain_req = 0;
    logic       in_ready, fl_wr_en, drain_done;
    logic [4:0] fl_wdata;
    logic [3:0] stage_count;
    int         n_chk = 0, n_fail = 0;

    typedef struct {
        logic       c0v, c0h;
        logic [4:0] c0p;
        logic       c1v, c1h;
        logic [4:0] c1p;
        logic       sqv;
        logic [4:0] sqp;
        logic       full, drq;
        logic       e_rdy, e_wr;
        logic [4:0] e_dat;
        logic [3:0] e_cnt;
        logic       e_done;
    } vec_t;

    vec_t tbl[$];

    preg_reclaim_unit dut (
        .clk(clk), .reset(reset),
        .c0_valid(c0_valid), .c0_has_dest(c0_has_dest), .c0_preg(c0_preg),
        .c1_valid(c1_valid), .c1_has_dest(c1_has_dest), .c1_preg(c1_preg),
        .sq_valid(sq_valid), .sq_preg(sq_preg), .in_ready(in_ready),
        .fl_full(fl_full), .fl_wr_en(fl_wr_en), .fl_wdata(fl_wdata),
        .drain_req(drain_req), .drain_done(drain_done), .stage_count(stage_count)
    );

    always #5 clk = ~clk;

    task automatic add(input int c0v, c0h, c0p, c1v, c1h, c1p, sqv, sqp, full, drq,
                       input int rdy, wr, dat, cnt, done);
        vec_t v;
        v.c0v = 1'(c0v); v.c0h = 1'(c0h); v.c0p = 5'(c0p);
        v.c1v = 1'(c1v); v.c1h = 1'(c1h); v.c1p = 5'(c1p);
        v.sqv = 1'(sqv); v.sqp = 5'(sqp); v.full = 1'(full); v.drq = 1'(drq);
        v.e_rdy = 1'(rdy); v.e_wr = 1'(wr); v.e_dat = 5'(dat); v.e_cnt = 4'(cnt); v.e_done = 1'(done);
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic a, input logic [4:0] ap, input logic b, input logic [4:0] bp,
                         input logic s, input logic [4:0] sp, input logic full, input logic drq);
        c0_valid = a; c0_has_dest = a; c0_preg = ap;
        c1_valid = b; c1_has_dest = b; c1_preg = bp;
        sq_valid = s; sq_preg = sp; fl_full = full; drain_req = drq;
    endtask

    initial begin
        int         v, mcount;
        logic       pend, rdy_exp, wr_exp;
        logic [4:0] pv [3];
        logic [4:0] sb[$];
        // reset state, then three-lane burst returns in lane order
        add(0,0,0, 0,0,0, 0,0, 0,0, 1,0,0,0,0);
        add(1,1,7, 1,1,9, 1,12, 0,0, 1,0,0,0,0);
        add(0,0,0, 0,0,0, 0,0, 0,0, 1,1,7,3,0);
        add(0,0,0, 0,0,0, 0,0, 0,0, 1,1,9,2,0);
        add(0,0,0, 0,0,0, 0,0, 0,0, 1,1,12,1,0);
        add(0,0,0, 0,0,0, 0,0, 0,0, 1,0,0,0,0);
        // unqualified lanes are dropped
        add(1,1,0, 1,0,5, 1,0, 0,0, 1,0,0,0,0);
        add(0,0,0, 0,0,0, 0,0, 0,0, 1,0,0,0,0);
        add(0,1,3, 0,0,0, 0,4, 0,0, 1,0,0,0,0);
        add(0,0,0, 0,0,0, 0,0, 0,0, 1,0,0,0,0);
        // backpressure: in_ready falls at 6, held burst enters once count is 5
        add(1,1,1, 1,1,2, 1,3, 1,0, 1,0,0,0,0);
        add(1,1,4, 1,1,5, 1,6, 1,0, 1,0,0,3,0);
        add(1,1,7, 1,1,8, 1,9, 1,0, 0,0,0,6,0);
        add(1,1,7, 1,1,8, 1,9, 0,0, 0,1,1,6,0);
        add(1,1,7, 1,1,8, 1,9, 0,0, 1,1,2,5,0);
        add(0,0,0, 0,0,0, 0,0, 0,0, 0,1,3,7,0);
        add(0,0,0, 0,0,0, 0,0, 0,0, 0,1,4,6,0);
        add(0,0,0, 0,0,0, 0,0, 0,0, 1,1,5,5,0);
        add(0,0,0, 0,0,0, 0,0, 0,0, 1,1,6,4,0);
        add(0,0,0, 0,0,0, 0,0, 0,0, 1,1,7,3,0);
        add(0,0,0, 0,0,0, 0,0, 0,0, 1,1,8,2,0);
        add(0,0,0, 0,0,0, 0,0, 0,0, 1,1,9,1,0);
        add(0,0,0, 0,0,0, 0,0, 0,0, 1,0,0,0,0);
        // drain with 4 queued; inputs during DRAIN ignored
        add(1,1,10, 1,1,11, 1,12, 1,0, 1,0,0,0,0);
        add(1,1,13, 0,0,0, 0,0, 1,0, 1,0,0,3,0);
        add(0,0,0, 0,0,0, 0,0, 0,1, 1,1,10,4,0);
        add(1,1,1, 1,1,2, 1,3, 0,0, 0,1,11,3,0);
        add(0,0,0, 0,0,0, 0,0, 0,0, 0,1,12,2,0);
        add(0,0,0, 0,0,0, 0,0, 0,0, 0,1,13,1,0);
        add(0,0,0, 0,0,0, 0,0, 0,0, 0,0,0,0,1);
        add(0,0,0, 0,0,0, 0,0, 0,0, 1,0,0,0,0);
        // drain on an empty queue: RUN, DRAIN, DONE
        add(0,0,0, 0,0,0, 0,0, 0,1, 1,0,0,0,0);
        add(0,0,0, 0,0,0, 0,0, 0,0, 0,0,0,0,0);
        add(0,0,0, 0,0,0, 0,0, 0,0, 0,0,0,0,1);
        add(0,0,0, 0,0,0, 0,0, 0,0, 1,0,0,0,0);

        repeat (2) @(negedge clk);
        reset = 0;
        foreach (tbl[i]) begin
            @(negedge clk);
            c0_valid = tbl[i].c0v; c0_has_dest = tbl[i].c0h; c0_preg = tbl[i].c0p;
            c1_valid = tbl[i].c1v; c1_has_dest = tbl[i].c1h; c1_preg = tbl[i].c1p;
            sq_valid = tbl[i].sqv; sq_preg = tbl[i].sqp;
            fl_full = tbl[i].full; drain_req = tbl[i].drq;
            #1;
            chk($sformatf("row%0d in_ready", i), int'(in_ready), int'(tbl[i].e_rdy));
            chk($sformatf("row%0d fl_wr_en", i), int'(fl_wr_en), int'(tbl[i].e_wr));
            chk($sformatf("row%0d stage_count", i), int'(stage_count), int'(tbl[i].e_cnt));
            chk($sformatf("row%0d drain_done", i), int'(drain_done), int'(tbl[i].e_done));
            if (tbl[i].e_wr) chk($sformatf("row%0d fl_wdata", i), int'(fl_wdata), int'(tbl[i].e_dat));
        end

        // wrap-around: bursts every other cycle against continuous draining
        v = 0; mcount = 0; pend = 0;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            if (!pend && i % 2 == 0 && i < 26) begin
                for (int k = 0; k < 3; k++) begin
                    v = v % 31 + 1;
                    pv[k] = 5'(v);
                end
                pend = 1;
            end
            drive(pend, pv[0], pend, pv[1], pend, pv[2], 0, 0);
            #1;
            rdy_exp = (mcount <= 5);
            wr_exp = (mcount != 0);
            chk($sformatf("wrap%0d in_ready", i), int'(in_ready), int'(rdy_exp));
            chk($sformatf("wrap%0d fl_wr_en", i), int'(fl_wr_en), int'(wr_exp));
            if (wr_exp) chk($sformatf("wrap%0d fl_wdata", i), int'(fl_wdata), int'(sb.pop_front()));
            if (pend && rdy_exp) begin
                for (int k = 0; k < 3; k++) sb.push_back(pv[k]);
                mcount += 3;
                pend = 0;
            end
            if (wr_exp) mcount--;
        end
        chk("wrap model empty", mcount, 0);
        chk("wrap stage_count", int'(stage_count), 0);

        // reset in the middle of DRAIN with 3 queued
        @(negedge clk); drive(1, 20, 1, 21, 1, 22, 1, 0); #1;
        chk("rst_drain in_ready", int'(in_ready), 1);
        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 1, 1); #1;
        chk("rst_drain count", int'(stage_count), 3);
        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 1, 0); #1;
        chk("rst_drain in DRAIN in_ready", int'(in_ready), 0);
        reset = 1;
        @(negedge clk); reset = 0; drive(0, 0, 0, 0, 0, 0, 0, 0); #1;
        chk("post_rst stage_count", int'(stage_count), 0);
        chk("post_rst fl_wr_en", int'(fl_wr_en), 0);
        chk("post_rst drain_done", int'(drain_done), 0);
        chk("post_rst in_ready", int'(in_ready), 1);
        @(negedge clk); #1;
        chk("post_rst2 drain_done", int'(drain_done), 0);
        chk("post_rst2 stage_count", int'(stage_count), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
